status_writeback: RTL and testbench

STATUS_WRITEBACK -- requirements
Module: status_writeback

---
 rtl/status_writeback.sv | 104 ++++++++++
 tb/tb_status_writeback.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/status_writeback.sv
// status_writeback: two-stage (M, W) pipeline carrying $rstatus writes from execute to the
// register file. It holds the architectural status register and gives execute-stage bex a
// forwarded "status non-zero" flag.
//
// Ports:
//   clock      - system clock, all state updates on the rising edge
//   reset      - asynchronous active-high reset, clears all state
//   stall      - pipeline hold; M, W and rstatus keep their contents
//   flush      - kills the status write of the execute-stage instruction
//   status_in  - status code for the execute-stage instruction
//   status_set - execute-stage instruction writes $rstatus
//   rs_we      - register-file write enable for $r30 (W stage valid)
//   rs_wdata   - register-file write data for $r30 (0 when rs_we is low)
//   rstatus    - architectural status value
//   bex_taken  - forwarded status value is non-zero
//   exc_count  - saturating count of committed status writes
//
// Optional feature: define STATUS_EXC_COUNT_EN to build the exc_count counter; otherwise
// exc_count is tied to zero and no counter flops exist.
module status_writeback (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [26:0] status_in,
  input  logic        status_set,
  output logic        rs_we,
  output logic [26:0] rs_wdata,
  output logic [26:0] rstatus,
  output logic        bex_taken,
  output logic [15:0] exc_count
);

  logic        m_valid_q;
  logic [26:0] m_data_q;
  logic        w_valid_q;
  logic [26:0] w_data_q;
  logic [26:0] rstatus_q;
  logic        commit;
  logic [26:0] fwd_value;

  // A write retires from W into rstatus on every unstalled edge where W holds a write.
  assign commit = w_valid_q & ~stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      rstatus_q <= '0;
    end else begin
      // Flush kills the execute-stage write even under stall; m_data is then don't-care and
      // simply holds.
      if (flush) begin
        m_valid_q <= 1'b0;
      end else if (!stall) begin
        m_valid_q <= status_set;
        m_data_q  <= status_in;
      end
      // W still advances on a flush: the instruction in M is older than the killed one.
      if (!stall) begin
        w_valid_q <= m_valid_q;
        w_data_q  <= m_data_q;
      end
      if (commit) begin
        rstatus_q <= w_data_q;
      end
    end
  end

  assign rs_we    = w_valid_q;
  assign rs_wdata = w_valid_q ? w_data_q : '0;
  assign rstatus  = rstatus_q;

  // Youngest in-flight write wins; a write of zero is still a write and forwards as zero.
  always_comb begin
    fwd_value = rstatus_q;
    if (m_valid_q) begin
      fwd_value = m_data_q;
    end else if (w_valid_q) begin
      fwd_value = w_data_q;
    end
  end

  assign bex_taken = |fwd_value;

`ifdef STATUS_EXC_COUNT_EN
  logic [15:0] exc_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exc_count_q <= '0;
    end else if (commit && (exc_count_q != 16'hFFFF)) begin
      exc_count_q <= exc_count_q + 16'd1;
    end
  end

  assign exc_count = exc_count_q;
`else
  assign exc_count = 16'h0000;
`endif

endmodule

// File: tb/tb_status_writeback.sv
// Testbench for status_writeback: directed scenarios plus randomized traffic, checked by a
// scoreboard. The driver pushes each accepted status write (tagged with the number of
// unstalled edges it has seen) into a queue; a monitor on the falling edge compares the DUT
// outputs against the queue and an architectural model of rstatus and the commit count.
module tb_status_writeback;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [26:0] status_in = '0;
  logic        status_set = 1'b0;
  logic        rs_we;
  logic [26:0] rs_wdata;
  logic [26:0] rstatus;
  logic        bex_taken;
  logic [15:0] exc_count;

  status_writeback dut (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .status_in  (status_in),
    .status_set (status_set),
    .rs_we      (rs_we),
    .rs_wdata   (rs_wdata),
    .rstatus    (rstatus),
    .bex_taken  (bex_taken),
    .exc_count  (exc_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [26:0] data;
    int          age;  // unstalled edges seen since capture
  } ent_t;

  ent_t        exp_q[$];
  logic [26:0] model_rs  = '0;
  logic [15:0] model_cnt = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock cycle of stimulus. Inputs change 2 time units after the rising edge.
  task automatic cyc(input bit s, input bit f, input bit st, input logic [26:0] d);
    status_set = s;
    flush      = f;
    stall      = st;
    status_in  = d;
    @(posedge clock);
    if (!reset) begin
      // Flush under stall kills the write still waiting in execute-to-M.
      if (f && st) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
          if (exp_q[i].age == 0) exp_q.delete(i);
        end
      end
      if (!st) begin
        foreach (exp_q[i]) exp_q[i].age++;
      end
      if (s && !f && !st) exp_q.push_back('{data: d, age: 0});
    end
    #2;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    exp_q.delete();
    model_rs  = '0;
    model_cnt = '0;
    repeat (cycles) @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  // Monitor / scoreboard.
  always @(negedge clock) begin
    logic [26:0] fwd;
    logic [15:0] exp_cnt;
    bit          exp_we;
    ent_t        e;
    exp_we = (exp_q.size() > 0) && (exp_q[0].age == 1);
    chk("rs_we", {31'd0, rs_we}, {31'd0, exp_we});
    chk("rs_wdata", {5'd0, rs_wdata}, exp_we ? {5'd0, exp_q[0].data} : 32'd0);
    chk("rstatus", {5'd0, rstatus}, {5'd0, model_rs});
    fwd = (exp_q.size() > 0) ? exp_q[$].data : model_rs;
    chk("bex_taken", {31'd0, bex_taken}, {31'd0, (fwd != 27'd0)});
`ifdef STATUS_EXC_COUNT_EN
    exp_cnt = model_cnt;
`else
    exp_cnt = 16'h0000;
`endif
    chk("exc_count", {16'd0, exc_count}, {16'd0, exp_cnt});
    if (exp_we && !stall && !reset) begin
      e = exp_q.pop_front();
      model_rs = e.data;
      if (model_cnt != 16'hFFFF) model_cnt++;
    end
  end

  function automatic logic [26:0] rand_val();
    logic [26:0] v;
    v = 27'($urandom);
    if ($urandom_range(0, 3) == 0) v = '0;
    return v;
  endfunction

  initial begin
    do_reset(2);

    // Single write of 1.
    cyc(1, 0, 0, 27'd1);
    repeat (3) cyc(0, 0, 0, 27'd0);
    #3 chk("single_rstatus", {5'd0, rstatus}, 32'd1);
    #4;

    // Back-to-back 2 then 3.
    cyc(1, 0, 0, 27'd2);
    cyc(1, 0, 0, 27'd3);
    repeat (3) cyc(0, 0, 0, 27'd0);
    #3 chk("b2b_rstatus", {5'd0, rstatus}, 32'd3);
    #4;

    // Flush on capture: nothing commits.
    do_reset(1);
    cyc(1, 1, 0, 27'h0F1);
    repeat (3) cyc(0, 0, 0, 27'd0);
    #3 chk("flush_rstatus", {5'd0, rstatus}, 32'd0);
    #4;

    // Write 5 then stall three cycles, then setx 0.
    cyc(1, 0, 0, 27'd5);
    repeat (3) cyc(0, 0, 1, 27'd0);
    cyc(0, 0, 0, 27'd0);
    repeat (3) cyc(0, 0, 1, 27'd0);
    repeat (2) cyc(0, 0, 0, 27'd0);
    #3 chk("stall_rstatus", {5'd0, rstatus}, 32'd5);
    #4;
    cyc(1, 0, 0, 27'd0);
    repeat (3) cyc(0, 0, 0, 27'd0);
    #3 chk("setx0_rstatus", {5'd0, rstatus}, 32'd0);
    chk("setx0_bex", {31'd0, bex_taken}, 32'd0);
    #4;

    // Flush under stall with a write in M and another in W.
    cyc(1, 0, 0, 27'd7);
    cyc(1, 0, 0, 27'd9);
    cyc(0, 1, 1, 27'd0);
    repeat (3) cyc(0, 0, 0, 27'd0);
    #3 chk("flush_stall_rstatus", {5'd0, rstatus}, 32'd7);
    #4;

    // Reset while a write sits in W.
    cyc(1, 0, 0, 27'd11);
    cyc(0, 0, 0, 27'd0);
    do_reset(1);
    repeat (3) cyc(0, 0, 0, 27'd0);
    #3 chk("reset_rstatus", {5'd0, rstatus}, 32'd0);
    #4;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end else begin
        cyc(bit'($urandom_range(0, 1)), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 4) == 0), rand_val());
      end
    end
    repeat (4) cyc(0, 0, 0, 27'd0);

`ifdef STATUS_EXC_COUNT_EN
    // Drive the commit count into saturation and beyond.
    do_reset(1);
    for (int i = 0; i < 65537; i++) cyc(1, 0, 0, rand_val());
    repeat (4) cyc(0, 0, 0, 27'd0);
    #3 chk("exc_saturated", {16'd0, exc_count}, 32'h0000FFFF);
    #4;
`endif

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
